sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Two-master arbiter sharing one single-port sram-style slave (addra/dina/douta/ena/wea, 1-cycle read latency), e.g. the data sram between the pipeline data port and a loader/DMA port.
- Same-cycle grant, round-robin fairness, bounded lock for atomic read-modify-write sequences.
- Sits between requesters and the sram_xbar/sram slave.

Parameters:
- LEN_ADDR, 64, address width
- LEN_DATA, 64, data width; must be a multiple of 8
- MAX_LOCK, 8, maximum consecutive cycles one master may hold a lock (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 access request this cycle
- m0_lock  in  1  master 0 requests exclusive ownership after its grant
- m0_addra  in  LEN_ADDR  master 0 address
- m0_dina  in  LEN_DATA  master 0 write data
- m0_wea  in  LEN_DATA/8  master 0 byte write enables (0 = read)
- m0_gnt  out  1  master 0 access accepted this cycle
- m0_rvalid  out  1  response for master 0's previous accepted access
- m0_douta  out  LEN_DATA  read data, valid with m0_rvalid
- m1_*  same set as m0_*, for master 1
- s_ena  out  1  slave enable
- s_addra  out  LEN_ADDR  slave address
- s_dina  out  LEN_DATA  slave write data
- s_wea  out  LEN_DATA/8  slave byte enables
- s_douta  in  LEN_DATA  slave read data, one cycle after s_ena

Behaviour:
- State: mode {IDLE, LOCKED}, owner (1b), last_gnt (1b), lock_cnt ($clog2(MAX_LOCK+1) bits), resp_valid, resp_id.
- Reset (rst=0, async): mode=IDLE, last_gnt=1, lock_cnt=0, resp_valid=0, resp_id=0. While rst=0: all gnt, rvalid and s_ena are 0; s_addra, s_dina and s_wea are 0.

Grant logic (combinational, zero latency):
- IDLE, single requester: that master is granted.
- IDLE, both requesting: the master != last_gnt wins. After reset m0 wins the first tie.
- LOCKED: only owner can be granted. The other master's gnt=0 regardless of req.
- Exactly one gnt or none per cycle. s_ena = any gnt.
- s_addra/s_dina/s_wea mux the winner's inputs. With no grant they are 0.
- A master holds req and its inputs until it sees gnt. The arbiter does not latch unaccepted requests.

Response path:
- On a grant, register resp_valid=1 and resp_id=winner. Otherwise resp_valid=0.
- Next cycle: mX_rvalid = resp_valid && resp_id==X.
- mX_douta = s_douta for both masters (unqualified). Data is meaningful only when rvalid is high.
- rvalid is asserted for writes too, as a completion acknowledge.

Lock FSM:
- IDLE -> LOCKED when the granted master has lock=1 in its grant cycle. owner=winner, lock_cnt=1.
- LOCKED, each cycle:
  - If owner lock=0: release to IDLE. A grant in that same cycle is still owner-only.
  - Else if lock_cnt==MAX_LOCK: forced release to IDLE.
  - Else lock_cnt++. The count includes cycles where the owner does not request, so idle owners cannot starve the other master.
- On any release: last_gnt=owner, lock_cnt=0.
- Re-locking: an owner still asserting lock and req after release competes normally. It loses the tie to the other master, and can only relock when it wins arbitration.
- last_gnt updates to the winner on every IDLE-mode grant. In LOCKED it stays at the owner.
- rst asserted mid-lock or mid-response: state clears immediately and the pending rvalid is dropped.

Test Plan:
- Reset, then m0 read addr 0x10 alone -> m0_gnt=1 and s_ena=1 in the same cycle, s_addra=0x10. Next cycle m0_rvalid=1 and m0_douta = sram word; m1_rvalid=0.
- Both masters request continuously (m0 write 0x20 wea=0xFF, m1 read 0x28) -> grants alternate m0, m1, m0, m1…, starting with m0. Each rvalid follows its own grant by exactly one cycle.
- m1 wins with lock=1 and holds lock for a read-then-write at 0x30 while m0 requests -> m0_gnt=0 until m1 drops lock. m0 is granted the cycle after release, and the write data is visible in the next m0 read.
- m0 holds lock=1 and req=1 indefinitely, MAX_LOCK=8, m1 requesting -> m0 granted exactly 8 consecutive cycles, then m1 granted in cycle 9.
- m0 locks, then deasserts req while keeping lock=1 with m1 requesting -> m1 blocked for at most MAX_LOCK cycles total, then granted.
- rst pulsed low in the cycle after a grant -> no rvalid appears, s_ena=0 during reset, and after release of reset m0 wins the first tie.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single-port SRAM: zero-latency grant,
// round-robin on ties, bounded exclusive lock for read-modify-write sequences.
module sram_arbiter #(
    parameter int unsigned LEN_ADDR = 64,
    parameter int unsigned LEN_DATA = 64,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_lock,
    input  logic [LEN_ADDR-1:0]   m0_addra,
    input  logic [LEN_DATA-1:0]   m0_dina,
    input  logic [LEN_DATA/8-1:0] m0_wea,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [LEN_DATA-1:0]   m0_douta,

    input  logic                  m1_req,
    input  logic                  m1_lock,
    input  logic [LEN_ADDR-1:0]   m1_addra,
    input  logic [LEN_DATA-1:0]   m1_dina,
    input  logic [LEN_DATA/8-1:0] m1_wea,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [LEN_DATA-1:0]   m1_douta,

    output logic                  s_ena,
    output logic [LEN_ADDR-1:0]   s_addra,
    output logic [LEN_DATA-1:0]   s_dina,
    output logic [LEN_DATA/8-1:0] s_wea,
    input  logic [LEN_DATA-1:0]   s_douta
);

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mode_e;

    mode_e             mode_q, mode_d;
    logic              owner_q, owner_d;
    logic              last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_id_q, resp_id_d;

    logic              gnt0, gnt1;
    logic              any_gnt;
    logic              win_lock;
    logic              owner_lock;

    // Grants are forced low while reset is held, independent of register state.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (mode_q == LOCKED) begin
                gnt0 = m0_req && !owner_q;
                gnt1 = m1_req && owner_q;
            end else if (m0_req && m1_req) begin
                gnt0 = last_gnt_q;
                gnt1 = !last_gnt_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
    end

    assign any_gnt    = gnt0 | gnt1;
    assign win_lock   = gnt1 ? m1_lock : m0_lock;
    assign owner_lock = owner_q ? m1_lock : m0_lock;

    always_comb begin
        s_ena   = any_gnt;
        s_addra = '0;
        s_dina  = '0;
        s_wea   = '0;
        if (gnt1) begin
            s_addra = m1_addra;
            s_dina  = m1_dina;
            s_wea   = m1_wea;
        end else if (gnt0) begin
            s_addra = m0_addra;
            s_dina  = m0_dina;
            s_wea   = m0_wea;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = resp_valid_q && !resp_id_q;
    assign m1_rvalid = resp_valid_q && resp_id_q;
    assign m0_douta  = s_douta;
    assign m1_douta  = s_douta;

    // lock_cnt counts cycles already owned; release fires on the cycle that
    // would make it reach MAX_LOCK, so the owner gets exactly MAX_LOCK grants.
    always_comb begin
        mode_d       = mode_q;
        owner_d      = owner_q;
        last_gnt_d   = last_gnt_q;
        lock_cnt_d   = lock_cnt_q;
        resp_valid_d = any_gnt;
        resp_id_d    = any_gnt ? gnt1 : resp_id_q;

        case (mode_q)
            IDLE: begin
                if (any_gnt) begin
                    last_gnt_d = gnt1;
                    if (win_lock && (MAX_LOCK > 1)) begin
                        mode_d     = LOCKED;
                        owner_d    = gnt1;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (!owner_lock || (lock_cnt_q == CNT_W'(MAX_LOCK - 1))) begin
                    mode_d     = IDLE;
                    last_gnt_d = owner_q;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                mode_d     = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q       <= IDLE;
            owner_q      <= 1'b0;
            last_gnt_q   <= 1'b1;
            lock_cnt_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            owner_q      <= owner_d;
            last_gnt_q   <= last_gnt_d;
            lock_cnt_q   <= lock_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
        end
    end

endmodule
